// File: rtl/sensor_mod_pkg.sv
// Register map, field positions and AXI constants for the SensorMod register block.
package sensor_mod_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PERIOD  = 3'd1;
    localparam logic [2:0] REG_THRESH  = 3'd2;
    localparam logic [2:0] REG_SCRATCH = 3'd3;
    localparam logic [2:0] REG_DATA    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STATUS_COUNT_LSB = 0;
    localparam int STATUS_ABOVE     = 16;
    localparam int STATUS_OVERRUN   = 17;
    localparam int STATUS_PENDING   = 18;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sensor_mod_sampler.sv
// Periodic sample-request timer with pending/overrun tracking and sample capture.
module sensor_mod_sampler
    import sensor_mod_pkg::*;
#(
    parameter int SENSOR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [31:0]             period,
    input  logic [SENSOR_WIDTH-1:0] thresh,
    input  logic                    status_clr,
    input  logic                    sensor_valid,
    input  logic [SENSOR_WIDTH-1:0] sensor_data,
    output logic                    sample_req,
    output logic [SENSOR_WIDTH-1:0] data,
    output logic [15:0]             count,
    output logic                    above,
    output logic                    overrun,
    output logic                    pending
);

    logic [31:0]             timer_q, timer_d;
    logic                    sample_req_q, sample_req_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             count_q, count_d;
    logic [SENSOR_WIDTH-1:0] data_q, data_d;
    logic                    above_q, above_d;
    logic                    expire;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        timer_d      = '0;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        count_d      = count_q;
        data_d       = data_q;
        above_d      = above_q;

        // >= rather than == so lowering PERIOD below the running timer still expires at once.
        expire       = enable && (timer_q >= period);
        sample_req_d = expire && !pending_q;
        if (enable && !expire) timer_d = timer_q + 32'd1;

        if (expire && pending_q) overrun_d = 1'b1;
        if (sensor_valid) begin
            pending_d = 1'b0;
            count_d   = count_q + 16'd1;
            data_d    = sensor_data;
            above_d   = sensor_data > thresh;
        end
        if (sample_req_d) pending_d = 1'b1;
        if (status_clr) begin
            count_d   = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            sample_req_q <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
            data_q       <= '0;
            above_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            timer_q      <= timer_d;
            sample_req_q <= sample_req_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            data_q       <= data_d;
            above_q      <= above_d;
        end
    end

    assign sample_req = sample_req_q;
    assign data       = data_q;
    assign count      = count_q;
    assign above      = above_q;
    assign overrun    = overrun_q;
    assign pending    = pending_q;

endmodule

// File: rtl/sensor_mod_s_axi_regs.sv
// AXI4-Lite slave exposing the SensorMod control, configuration and status registers.
module sensor_mod_s_axi_regs
    import sensor_mod_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_SENSOR_WIDTH     = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            sample_req,
    input  logic                            sensor_valid,
    input  logic [C_SENSOR_WIDTH-1:0]       sensor_data,
    output logic                            irq
);

    logic [31:0] ctrl_q, ctrl_d, period_q, period_d;
    logic [31:0] thresh_q, thresh_d, scratch_q, scratch_d;
    logic [31:0] rdata_q, rdata_d, rd_word;
    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic        irq_q, irq_d;
    logic        wr_en, rd_en, status_clr;
    logic [2:0]  wr_idx, rd_idx;

    logic [C_SENSOR_WIDTH-1:0] smp_data;
    logic [15:0]               smp_count;
    logic                      smp_above, smp_overrun, smp_pending;

    // The master holds address/data until ready, so the register update uses them on the ready edge.
    assign wr_en      = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en      = arready_q && S_AXI_ARVALID;
    assign wr_idx     = S_AXI_AWADDR[4:2];
    assign rd_idx     = S_AXI_ARADDR[4:2];
    assign status_clr = wr_en && (wr_idx == REG_STATUS);

    always_comb begin
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
        arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
        bvalid_d  = bvalid_q && !S_AXI_BREADY;
        rvalid_d  = rvalid_q && !S_AXI_RREADY;
        rdata_d   = rdata_q;
        ctrl_d    = ctrl_q;
        period_d  = period_q;
        thresh_d  = thresh_q;
        scratch_d = scratch_q;
        rd_word   = '0;

        if (wr_en) begin
            bvalid_d = 1'b1;
            case (wr_idx)
                REG_CTRL:    ctrl_d    = apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
                REG_PERIOD:  period_d  = apply_wstrb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
                REG_THRESH:  thresh_d  = apply_wstrb(thresh_q, S_AXI_WDATA, S_AXI_WSTRB);
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end

        case (rd_idx)
            REG_CTRL:    rd_word = ctrl_q;
            REG_PERIOD:  rd_word = period_q;
            REG_THRESH:  rd_word = thresh_q;
            REG_SCRATCH: rd_word = scratch_q;
            REG_DATA:    rd_word = 32'(smp_data);
            REG_STATUS: begin
                rd_word[STATUS_COUNT_LSB +: 16] = smp_count;
                rd_word[STATUS_ABOVE]           = smp_above;
                rd_word[STATUS_OVERRUN]         = smp_overrun;
                rd_word[STATUS_PENDING]         = smp_pending;
            end
            default: ;
        endcase
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end

        irq_d = ctrl_q[CTRL_IRQ_EN] && smp_above;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q    <= '0;
            period_q  <= '0;
            thresh_q  <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            thresh_q  <= thresh_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
        end
    end

    sensor_mod_sampler #(
        .SENSOR_WIDTH (C_SENSOR_WIDTH)
    ) u_sampler (
        .clk          (S_AXI_ACLK),
        .rst_n        (S_AXI_ARESETN),
        .enable       (ctrl_q[CTRL_ENABLE]),
        .period       (period_q),
        .thresh       (thresh_q[C_SENSOR_WIDTH-1:0]),
        .status_clr   (status_clr),
        .sensor_valid (sensor_valid),
        .sensor_data  (sensor_data),
        .sample_req   (sample_req),
        .data         (smp_data),
        .count        (smp_count),
        .above        (smp_above),
        .overrun      (smp_overrun),
        .pending      (smp_pending)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign irq           = irq_q;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], thresh_q};

endmodule

// File: tb/tb_sensor_mod_s_axi_regs.sv
// Directed bench for sensor_mod_s_axi_regs: register access, strobes, sampler, backpressure, reset.
module tb_sensor_mod_s_axi_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        sample_req, sensor_valid, irq;
    logic [15:0] sensor_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          pulses;
    int          n;
    int          req_cyc [3];
    logic [31:0] rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sensor_mod_s_axi_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sample_req    (sample_req),
        .sensor_valid  (sensor_valid),
        .sensor_data   (sensor_data),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; sensor_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF,
                             input bit with_valid = 1'b0, input logic [15:0] vdata = 16'h0);
        int k = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        do begin @(posedge clk); #1; k++; end while (!awready && k < 20);
        check("wr_accept", 32'({awready, wready}), 32'h3);
        last_hs = cyc + 1;
        if (with_valid) begin sensor_valid = 1'b1; sensor_data = vdata; end
        @(posedge clk); #1;
        sensor_valid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bresp", 32'({bvalid, bresp}), 32'h4);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int k = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        do begin @(posedge clk); #1; k++; end while (!arready && k < 20);
        check("rd_accept", 32'(arready), 32'h1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rd_rresp", 32'({rvalid, rresp}), 32'h4);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        sensor_valid = 1'b0; sensor_data = '0;

        #12;
        check("reset_flags", 32'({awready, wready, bvalid, arready, rvalid, sample_req, irq}), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_resp", 32'({bresp, rresp}), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic RW readback, plus RO and unmapped writes being ignored.
        axi_write(5'h00, 32'h1);
        axi_write(5'h04, 32'h2);
        axi_write(5'h08, 32'h3);
        axi_write(5'h0C, 32'h4);
        axi_write(5'h10, 32'hFFFF_FFFF);
        axi_write(5'h18, 32'hFFFF_FFFF);
        read_check("rb_ctrl", 5'h00, 32'h1);
        read_check("rb_period", 5'h04, 32'h2);
        read_check("rb_thresh", 5'h08, 32'h3);
        read_check("rb_scratch", 5'h0C, 32'h4);
        read_check("rb_data_ro", 5'h10, 32'h0);
        read_check("rb_unmapped", 5'h18, 32'h0);

        // Byte-lane strobe on SCRATCH.
        axi_write(5'h0C, 32'h1122_3344);
        axi_write(5'h0C, 32'hAABB_CCDD, 4'b0010);
        read_check("wstrb_scratch", 5'h0C, 32'h1122_CC44);

        // PERIOD=3: a request every 4 cycles, each answered with 0x50 against THRESH=0x40.
        do_reset();
        axi_write(5'h08, 32'h40);
        axi_write(5'h04, 32'h3);
        axi_write(5'h00, 32'h1);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!sample_req && n < 20) begin @(posedge clk); #1; n++; end
            check("req_seen", 32'(sample_req), 32'h1);
            req_cyc[i] = cyc;
            sensor_valid = 1'b1; sensor_data = 16'h0050;
            @(posedge clk); #1;
            sensor_valid = 1'b0;
        end
        check("req_first_latency", 32'(req_cyc[0] - last_hs), 32'd4);
        check("req_interval_1", 32'(req_cyc[1] - req_cyc[0]), 32'd4);
        check("req_interval_2", 32'(req_cyc[2] - req_cyc[1]), 32'd4);
        check("irq_disabled", 32'(irq), 32'h0);
        read_check("status_three", 5'h14, 32'h0001_0003);
        read_check("data_captured", 5'h10, 32'h0000_0050);
        axi_write(5'h00, 32'h3);
        check("irq_enabled", 32'(irq), 32'h1);

        // PERIOD=1 without answers: one request, then overruns; STATUS write clears.
        do_reset();
        axi_write(5'h04, 32'h1);
        axi_write(5'h00, 32'h1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (sample_req) pulses++;
        end
        check("overrun_one_req", 32'(pulses), 32'd1);
        read_check("status_overrun", 5'h14, 32'h0006_0000);
        axi_write(5'h00, 32'h0);
        sensor_valid = 1'b1; sensor_data = 16'h0010;
        @(posedge clk); #1;
        sensor_valid = 1'b0;
        read_check("status_late_sample", 5'h14, 32'h0003_0001);
        axi_write(5'h14, 32'h0);
        read_check("status_cleared", 5'h14, 32'h0001_0000);
        axi_write(5'h08, 32'h40);
        axi_write(5'h14, 32'h0, 4'hF, 1'b1, 16'h0030);
        read_check("status_clear_wins", 5'h14, 32'h0000_0000);
        read_check("data_with_clear", 5'h10, 32'h0000_0030);

        // Backpressure: responses held while a second write/read waits.
        do_reset();
        axi_write(5'h0C, 32'h1234_5678);
        awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check("bp_both_ready", 32'({awready, arready}), 32'h3);
        @(posedge clk); #1;
        wdata = 32'h99;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_flags", 32'({bvalid, rvalid, awready, arready}), 32'hC);
            check("bp_hold_rdata", rdata, 32'h1234_5678);
        end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({bvalid, rvalid}), 32'h0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check("bp_second_ready", 32'({awready, arready}), 32'h3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("bp_second_resp", 32'({bvalid, rvalid}), 32'h3);
        check("bp_second_rdata", rdata, 32'h55);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        read_check("bp_final_scratch", 5'h0C, 32'h99);

        // Reset with a pending sample and an unaccepted write response.
        do_reset();
        axi_write(5'h04, 32'h1);
        axi_write(5'h00, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        axi_read(5'h14, rd);
        check("rst_pending_set", 32'(rd[18]), 32'h1);
        awaddr = 5'h0C; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("rst_bvalid_set", 32'(bvalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", 32'({awready, wready, bvalid, arready, rvalid, sample_req, irq}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_bresp", 32'(bvalid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(i * 4), rd);
            check($sformatf("rst_reg_%0d", i), rd, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
